bin_to_bcd_seq: RTL and testbench

//   Sequential double-dabble binary-to-BCD converter, one shift step per clock.

---
 rtl/bin_conv_pkg.sv | 45 ++++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bin_conv_pkg.sv
// Shared types and constants for the binary conversion blocks: converter FSM states,
// double-dabble adjust constants and the 7-segment {g,f,e,d,c,b,a} lookup.
package bin_conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   localparam logic [6:0] SEG_0   = 7'b0111111;
   localparam logic [6:0] SEG_1   = 7'b0000110;
   localparam logic [6:0] SEG_2   = 7'b1011011;
   localparam logic [6:0] SEG_3   = 7'b1001111;
   localparam logic [6:0] SEG_4   = 7'b1100110;
   localparam logic [6:0] SEG_5   = 7'b1101101;
   localparam logic [6:0] SEG_6   = 7'b1111101;
   localparam logic [6:0] SEG_7   = 7'b0000111;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1101111;
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   // Nibbles 10..15 are not BCD and blank the digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
   import bin_conv_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adj
);

   assign adj = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift step per clock, with
// valid/ready on both sides. Define BIN_TO_BCD_SEG_EN to add the registered seg_out decode.
module bin_to_bcd_seq
   import bin_conv_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf,
   output logic                  busy
`ifdef BIN_TO_BCD_SEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg_out
`endif
);

   localparam int BW = 4*DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH-1);

   conv_state_t     state, state_next;
   logic [SW-1:0]   shift_reg, shift_next;
   logic [BW-1:0]   adj_bcd;
   logic [CW-1:0]   count;
   logic            last_step;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (shift_reg[WIDTH+4*i +: 4]),
         .adj   (adj_bcd[4*i +: 4])
      );
   end

   assign shift_next = {adj_bcd, shift_reg[WIDTH-1:0]} << 1;
   assign last_step  = (count == LAST_STEP);

   assign in_ready  = (state == IDLE);
   assign busy      = (state == SHIFT);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = SHIFT;
         SHIFT:   if (last_step) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef BIN_TO_BCD_SEG_EN
   logic [7*DIGITS-1:0] seg_next;

   always_comb begin
      seg_next = '0;
      for (int i = 0; i < DIGITS; i++)
         seg_next[7*i +: 7] = seg_decode(shift_next[WIDTH+4*i +: 4]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seg_out <= '0;
      else if (state == SHIFT && last_step)
         seg_out <= seg_next;
   end
`endif

   // The bit leaving the top digit is a carry past 10**DIGITS-1, so it accumulates into ovf.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         bcd_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_reg <= {{BW{1'b0}}, bin_in};
                  count     <= '0;
                  ovf       <= 1'b0;
               end
            end
            SHIFT: begin
               shift_reg <= shift_next;
               ovf       <= ovf | adj_bcd[BW-1];
               count     <= count + CW'(1);
               if (last_step)
                  bcd_out <= shift_next[SW-1:WIDTH];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit converter run in lockstep from the same
// stimulus; expected results are queued at the input handshake and compared at the output one.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  bin_in;
   logic        out_ready;

   logic        in_ready,  out_valid,  ovf,  busy;
   logic        in_ready2, out_valid2, ovf2, busy2;
   logic [11:0] bcd_out;
   logic [7:0]  bcd_out2;
`ifdef BIN_TO_BCD_SEG_EN
   logic [20:0] seg_out;
   logic [13:0] seg_out2;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [11:0] bcd3;
      logic        ovf3;
      logic [7:0]  bcd2;
      logic        ovf2;
      logic [20:0] seg3;
      logic [13:0] seg2;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
      .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .ovf(ovf), .busy(busy)
`ifdef BIN_TO_BCD_SEG_EN
      , .seg_out(seg_out)
`endif
   );

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .bin_in(bin_in),
      .out_valid(out_valid2), .out_ready(out_ready), .bcd_out(bcd_out2), .ovf(ovf2), .busy(busy2)
`ifdef BIN_TO_BCD_SEG_EN
      , .seg_out(seg_out2)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [6:0] segOf(input int d);
      case (d)
         0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
         3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
         6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
         9: return 7'b1101111;  default: return 7'b0000000;
      endcase
   endfunction

   function automatic exp_t model(input int v);
      exp_t e;
      int   r;
      e = '{default: '0};
      r = v;
      for (int i = 0; i < 3; i++) begin
         e.bcd3[4*i +: 4] = 4'(r % 10);
         e.seg3[7*i +: 7] = segOf(r % 10);
         if (i < 2) begin
            e.bcd2[4*i +: 4] = 4'(r % 10);
            e.seg2[7*i +: 7] = segOf(r % 10);
         end
         r = r / 10;
      end
      e.ovf3 = (v > 999);
      e.ovf2 = (v > 99);
      return e;
   endfunction

   task automatic checkResult(input exp_t e);
      checkOutput("out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("out_valid2", {31'b0, out_valid2}, 32'd1);
      checkOutput("bcd3", {20'b0, bcd_out}, {20'b0, e.bcd3});
      checkOutput("ovf3", {31'b0, ovf}, {31'b0, e.ovf3});
      checkOutput("bcd2", {24'b0, bcd_out2}, {24'b0, e.bcd2});
      checkOutput("ovf2", {31'b0, ovf2}, {31'b0, e.ovf2});
`ifdef BIN_TO_BCD_SEG_EN
      checkOutput("seg3", {11'b0, seg_out}, {11'b0, e.seg3});
      checkOutput("seg2", {18'b0, seg_out2}, {18'b0, e.seg2});
`endif
   endtask

   // Called at a negedge; returns at a negedge with the converters back in IDLE.
   task automatic applyStimulus(input logic [7:0] v, input int stall);
      int   cycles;
      int   busy_cycles;
      exp_t e;
      cycles = 0;
      while (!in_ready && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      bin_in   = v;
      sb.push_back(model(int'(v)));
      @(negedge clk);
      bin_in = 8'($urandom);
      cycles = 0;
      busy_cycles = 0;
      while (!out_valid && cycles < 50) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         bin_in = 8'($urandom);
         cycles++;
      end
      checkOutput("latency", cycles, 32'd8);
      checkOutput("busy_cycles", busy_cycles, 32'd8);
      e = sb[0];
      for (int i = 0; i < stall; i++) begin
         checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("stall_bcd3", {20'b0, bcd_out}, {20'b0, e.bcd3});
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sb.size() > 0) checkResult(sb.pop_front());
      else checkOutput("sb_empty", 32'd1, 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("in_ready_after", {31'b0, in_ready}, 32'd1);
      checkOutput("out_valid_after", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      bin_in    = '0;
      out_ready = 1'b0;
      #12;
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_bcd", {20'b0, bcd_out}, 32'd0);
      checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(8'd255, 0);
      applyStimulus(8'd0, 0);
      applyStimulus(8'd99, 0);
      applyStimulus(8'd128, 5);
      applyStimulus(8'd200, 0);
      applyStimulus(8'd7, 2);
      for (int k = 0; k < 4; k++) applyStimulus(8'($urandom), k);

      // Abort a conversion after four shift steps.
      in_valid = 1'b1;
      bin_in   = 8'd173;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pre_rst_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("mid_rst_bcd", {20'b0, bcd_out}, 32'd0);
      checkOutput("mid_rst_ovf", {31'b0, ovf2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(8'd42, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
